// File: rtl/breakout_pkg.sv
// Shared breakout constants: field geometry, row masks, init FSM encoding
// and a popcount helper used when loading a level.
package breakout_pkg;

  localparam int BLOCKS_PER_ROW = 13;
  localparam int NUM_ROWS       = 16;
  localparam int FILLED_ROWS    = 8;

  localparam int ROW_W = 4;
  localparam int COL_W = 4;
  localparam int POP_W = 4;
  localparam int CNT_W = 8;

  localparam logic [BLOCKS_PER_ROW-1:0] ROW_MASK_FULL = 13'h1FFF;
  localparam logic [BLOCKS_PER_ROW-1:0] ROW_MASK_ALT  = 13'h0AAA;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } init_state_t;

  function automatic logic [POP_W-1:0] popcount(input logic [BLOCKS_PER_ROW-1:0] m);
    logic [POP_W-1:0] pc;
    pc = '0;
    for (int i = 0; i < BLOCKS_PER_ROW; i++) begin
      pc = pc + {{(POP_W-1){1'b0}}, m[i]};
    end
    return pc;
  endfunction

endpackage

// File: rtl/block_state_store_if.sv
// Collision request/response handshake between the collision logic
// (master) and the block store (slave).
interface block_state_store_if;
  logic                        hit_valid;
  logic                        hit_ready;
  logic [breakout_pkg::ROW_W-1:0] hit_row;
  logic [breakout_pkg::COL_W-1:0] hit_col;
  logic                        hit_resp_valid;
  logic                        hit_resp_present;

  modport master (
    output hit_valid, hit_row, hit_col,
    input  hit_ready, hit_resp_valid, hit_resp_present
  );

  modport slave (
    input  hit_valid, hit_row, hit_col,
    output hit_ready, hit_resp_valid, hit_resp_present
  );
endinterface

// File: rtl/block_row_pattern.sv
// Level-load row pattern: mask and popcount for a given row index.
// BLOCK_STATE_PATTERN_EN selects the alternating pattern on odd rows.
module block_row_pattern
  import breakout_pkg::*;
(
  input  logic [ROW_W-1:0]          row,
  output logic [BLOCKS_PER_ROW-1:0] mask,
  output logic [POP_W-1:0]          pop
);

  always_comb begin
    mask = '0;
    if (int'(row) < FILLED_ROWS) begin
`ifdef BLOCK_STATE_PATTERN_EN
      mask = row[0] ? ROW_MASK_ALT : ROW_MASK_FULL;
`else
      mask = ROW_MASK_FULL;
`endif
    end
    pop = popcount(mask);
  end

endmodule

// File: rtl/block_state_store.sv
// Breakout block field store: painter row readout, collision hit/clear
// handshake and row-by-row level init. Optional macro: BLOCK_STATE_PATTERN_EN.
//
// state   | meaning
// ST_INIT | writing one row per cycle from the level pattern; hits blocked
// ST_IDLE | field stable; hit requests accepted
module block_state_store
  import breakout_pkg::*;
(
  input  logic                      clk,
  input  logic                      nRst,
  input  logic                      new_frame,
  input  logic                      go_next_line,
  output logic [BLOCKS_PER_ROW-1:0] block_line_state,
  input  logic                      level_load,
  output logic                      init_busy,
  block_state_store_if.slave        hit,
  output logic [CNT_W-1:0]          blocks_remaining,
  output logic                      all_cleared
);

  logic [BLOCKS_PER_ROW-1:0] rows [NUM_ROWS];
  init_state_t               state;
  logic [ROW_W-1:0]          init_row;
  logic [ROW_W-1:0]          row_ptr;
  logic [CNT_W-1:0]          count;

  logic [BLOCKS_PER_ROW-1:0] pat_mask;
  logic [POP_W-1:0]          pat_pop;

  logic                      accept;
  logic                      col_ok;
  logic [BLOCKS_PER_ROW-1:0] hit_word;
  logic                      hit_bit;

  block_row_pattern u_pattern (
    .row  (init_row),
    .mask (pat_mask),
    .pop  (pat_pop)
  );

  assign hit.hit_ready = (state == ST_IDLE) && !level_load;
  assign accept        = hit.hit_valid && hit.hit_ready;
  assign col_ok        = int'(hit.hit_col) < BLOCKS_PER_ROW;
  assign hit_word      = rows[hit.hit_row];
  // Out-of-field columns are gated before the bit select is used.
  assign hit_bit       = col_ok && hit_word[hit.hit_col];

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int r = 0; r < NUM_ROWS; r++) rows[r] <= '0;
      state                <= ST_INIT;
      init_row             <= '0;
      count                <= '0;
      hit.hit_resp_valid   <= 1'b0;
      hit.hit_resp_present <= 1'b0;
    end else begin
      hit.hit_resp_valid   <= accept;
      hit.hit_resp_present <= accept && hit_bit;
      if (level_load) begin
        state    <= ST_INIT;
        init_row <= '0;
        count    <= '0;
      end else begin
        case (state)
          ST_INIT: begin
            rows[init_row] <= pat_mask;
            count          <= count + {{(CNT_W-POP_W){1'b0}}, pat_pop};
            init_row       <= init_row + 1'b1;
            if (init_row == ROW_W'(NUM_ROWS - 1)) state <= ST_IDLE;
          end
          ST_IDLE: begin
            if (accept && hit_bit) begin
              rows[hit.hit_row][hit.hit_col] <= 1'b0;
              if (count != '0) count <= count - 1'b1;
            end
          end
          default: state <= ST_INIT;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      row_ptr <= '0;
    end else if (new_frame) begin
      row_ptr <= '0;
    end else if (go_next_line) begin
      row_ptr <= row_ptr + 1'b1;
    end
  end

  assign block_line_state = rows[row_ptr];
  assign init_busy        = (state == ST_INIT);
  assign blocks_remaining = count;
  assign all_cleared      = (count == '0) && (state == ST_IDLE);

endmodule

// File: tb/tb_block_state_store.sv
// Randomised scoreboard bench for block_state_store against a field-level model.
module tb_block_state_store;
  import breakout_pkg::*;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        new_frame = 1'b0;
  logic        go_next_line = 1'b0;
  logic        level_load = 1'b0;
  logic [12:0] block_line_state;
  logic        init_busy;
  logic [7:0]  blocks_remaining;
  logic        all_cleared;

  block_state_store_if bus ();

  block_state_store dut (
    .clk              (clk),
    .nRst             (nRst),
    .new_frame        (new_frame),
    .go_next_line     (go_next_line),
    .block_line_state (block_line_state),
    .level_load       (level_load),
    .init_busy        (init_busy),
    .hit              (bus),
    .blocks_remaining (blocks_remaining),
    .all_cleared      (all_cleared)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic present;
    int   count;
  } resp_t;
  resp_t exp_q[$];

  logic [12:0] m_rows [16];
  int          m_count;
  int          m_ptr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [12:0] spec_mask(input int r);
    if (r >= 8) return 13'h0000;
`ifdef BLOCK_STATE_PATTERN_EN
    if (r % 2 == 1) return 13'h0AAA;
`endif
    return 13'h1FFF;
  endfunction

  task automatic model_load();
    m_count = 0;
    for (int r = 0; r < 16; r++) begin
      m_rows[r] = spec_mask(r);
      m_count += $countones(m_rows[r]);
    end
  endtask

  function automatic logic model_hit(input int r, input int c);
    if (c >= 13) return 1'b0;
    if (!m_rows[r][c]) return 1'b0;
    m_rows[r][c] = 1'b0;
    if (m_count > 0) m_count--;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(output int cyc);
    cyc = 0;
    while (init_busy === 1'b1 && cyc < 40) begin
      tick();
      cyc++;
      if (cyc == 8) begin
        check("mid_init_all_cleared", all_cleared, 0);
        check("mid_init_hit_ready", bus.hit_ready, 0);
      end
    end
  endtask

  task automatic pulse_next();
    go_next_line = 1'b1;
    tick();
    go_next_line = 1'b0;
    m_ptr = (m_ptr + 1) % 16;
  endtask

  task automatic pulse_frame();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    m_ptr = 0;
  endtask

  task automatic hit(input int r, input int c);
    resp_t e;
    bus.hit_valid = 1'b1;
    bus.hit_row   = 4'(r);
    bus.hit_col   = 4'(c);
    #1;
    check("hit_ready", bus.hit_ready, 1);
    e.present = model_hit(r, c);
    e.count   = m_count;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic hit_end();
    bus.hit_valid = 1'b0;
    tick();
  endtask

  // Response monitor: pops the scoreboard whenever the DUT presents a response.
  initial begin
    forever begin
      resp_t e;
      @(negedge clk);
      if (bus.hit_resp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got response with none pending at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("resp_present", bus.hit_resp_present, e.present);
          check("resp_count", blocks_remaining, e.count);
        end
      end
    end
  end

  initial begin
    int cyc;
    bus.hit_valid = 1'b0;
    bus.hit_row   = '0;
    bus.hit_col   = '0;
    m_ptr = 0;
    m_count = 0;

    #12;
    check("rst_init_busy", init_busy, 1);
    check("rst_hit_ready", bus.hit_ready, 0);
    check("rst_line_state", block_line_state, 0);
    check("rst_count", blocks_remaining, 0);
    check("rst_all_cleared", all_cleared, 0);
    check("rst_resp_valid", bus.hit_resp_valid, 0);
    check("rst_resp_present", bus.hit_resp_present, 0);

    @(posedge clk);
    #1;
    nRst = 1'b1;
    wait_init(cyc);
    check("init_cycles", cyc, 16);
    model_load();
    check("init_count", blocks_remaining, m_count);
    check("init_line_state", block_line_state, m_rows[0]);
    check("init_hit_ready", bus.hit_ready, 1);
    check("init_all_cleared", all_cleared, 0);

    for (int i = 1; i <= 8; i++) begin
      pulse_next();
      check("row_ptr_line", block_line_state, m_rows[m_ptr]);
    end
    pulse_frame();
    check("new_frame_line", block_line_state, m_rows[0]);
    pulse_next();
    new_frame = 1'b1;
    go_next_line = 1'b1;
    tick();
    new_frame = 1'b0;
    go_next_line = 1'b0;
    m_ptr = 0;
    check("frame_priority_line", block_line_state, m_rows[0]);

    hit(2, 5);
    hit(2, 5);
    hit_end();
    pulse_next();
    pulse_next();
    check("row2_after_hit", block_line_state, 13'h1FDF);
    check("row2_model", block_line_state, m_rows[2]);

    hit(3, 13);
    hit(0, 15);
    hit_end();
    check("bad_col_count", blocks_remaining, m_count);

    bus.hit_valid = 1'b1;
    bus.hit_row   = 4'd0;
    bus.hit_col   = 4'd0;
    level_load    = 1'b1;
    #1;
    check("load_blocks_ready", bus.hit_ready, 0);
    tick();
    level_load    = 1'b0;
    bus.hit_valid = 1'b0;
    check("load_busy", init_busy, 1);
    check("load_count_zero", blocks_remaining, 0);
    wait_init(cyc);
    check("reload_cycles", cyc, 16);
    model_load();
    check("reload_count", blocks_remaining, m_count);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(3) == 0) begin
        hit_end();
      end else begin
        hit(int'($urandom_range(15)), int'($urandom_range(15)));
      end
    end
    hit_end();
    check("rand_count", blocks_remaining, m_count);
    check("rand_line_state", block_line_state, m_rows[m_ptr]);

    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 13; c++) begin
        if (m_rows[r][c]) hit(r, c);
      end
    end
    hit_end();
    check("cleared_count", blocks_remaining, 0);
    check("cleared_flag", all_cleared, 1);
    hit(0, 0);
    hit_end();
    check("no_underflow", blocks_remaining, 0);

    level_load = 1'b1;
    tick();
    level_load = 1'b0;
    check("load_drops_cleared", all_cleared, 0);
    check("load_busy2", init_busy, 1);
    wait_init(cyc);
    model_load();
    check("reload2_count", blocks_remaining, m_count);
    check("reload2_all_cleared", all_cleared, 0);

    level_load = 1'b1;
    tick();
    level_load = 1'b0;
    repeat (5) tick();
    nRst = 1'b0;
    #1;
    check("midinit_rst_count", blocks_remaining, 0);
    check("midinit_rst_busy", init_busy, 1);
    check("midinit_rst_line", block_line_state, 0);
    check("midinit_rst_ready", bus.hit_ready, 0);
    tick();
    nRst = 1'b1;
    m_ptr = 0;
    wait_init(cyc);
    check("rst_reinit_cycles", cyc, 16);
    model_load();
    check("rst_reinit_count", blocks_remaining, m_count);
    check("rst_reinit_line", block_line_state, m_rows[0]);

    tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
